// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared types and constants for the RV32M divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
package md_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DIV_ITER = 32;
    localparam int CNT_W    = $clog2(DIV_ITER);

    // DIV and REM are the signed encodings (op bit 0 clear).
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring-division iteration: shift, compare, subtract.
//  Revision    : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] i_rem,
    input  logic [Width-1:0] i_dvd,
    input  logic [Width-1:0] i_dvs,
    output logic [Width-1:0] o_rem,
    output logic [Width-1:0] o_dvd
);

    logic [Width:0] w_shift;
    logic [Width:0] w_diff;
    logic           w_fit;

    assign w_shift = {i_rem, i_dvd[Width-1]};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    // Partial remainder stays below the divisor, so a clear MSB means no borrow.
    assign w_fit   = ~w_diff[Width];

    assign o_rem = w_fit ? w_diff[Width-1:0] : w_shift[Width-1:0];
    assign o_dvd = {i_dvd[Width-2:0], w_fit};

endmodule
`default_nettype wire

// File: rtl/rv_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rv_div_unit
//  Description : 32-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//  Revision    : 1.0  initial release
// ============================================================================
module rv_div_unit #(
    parameter int Width    = 32,
    parameter int RegAddrW = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [1:0]          op_i,
    input  logic [Width-1:0]    rs1_i,
    input  logic [Width-1:0]    rs2_i,
    input  logic [RegAddrW-1:0] rd_i,
    input  logic                abort_i,
    output logic                ready_o,
    output logic                busy_o,
    output logic                valid_o,
    output logic [Width-1:0]    result_o,
    output logic [RegAddrW-1:0] rd_o
);

    import md_pkg::*;

    localparam logic [Width-1:0] C_INT_MIN = {1'b1, {(Width-1){1'b0}}};
    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(DIV_ITER - 1);

    div_state_e            r_state;
    md_op_e                r_op;
    logic [RegAddrW-1:0]   r_rd;
    logic [RegAddrW-1:0]   r_rd_out;
    logic [Width-1:0]      r_dvd;
    logic [Width-1:0]      r_dvs;
    logic [Width-1:0]      r_rem;
    logic [Width-1:0]      r_result;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_valid;

    logic                  w_signed_req;
    logic                  w_sign1;
    logic                  w_sign2;
    logic [Width-1:0]      w_abs1;
    logic [Width-1:0]      w_abs2;
    logic                  w_div_zero;
    logic                  w_ovf;
    logic [Width-1:0]      w_spec_res;
    logic [Width-1:0]      w_rem_nxt;
    logic [Width-1:0]      w_dvd_nxt;
    logic                  w_fix_signed;
    logic [Width-1:0]      w_quo_fix;
    logic [Width-1:0]      w_rem_fix;

    assign w_signed_req = is_signed_op(op_i);
    assign w_sign1      = w_signed_req & rs1_i[Width-1];
    assign w_sign2      = w_signed_req & rs2_i[Width-1];
    assign w_abs1       = w_sign1 ? (~rs1_i + Width'(1)) : rs1_i;
    assign w_abs2       = w_sign2 ? (~rs2_i + Width'(1)) : rs2_i;

    // Cases with an architecturally fixed answer bypass the iteration.
    assign w_div_zero = (rs2_i == '0);
    assign w_ovf      = w_signed_req & (rs1_i == C_INT_MIN) & (&rs2_i);
    assign w_spec_res = op_i[1] ? (w_div_zero ? rs1_i : '0)
                                : (w_div_zero ? '1 : C_INT_MIN);

    assign w_fix_signed = is_signed_op(r_op);
    assign w_quo_fix    = (w_fix_signed & r_neg_q) ? (~r_dvd + Width'(1)) : r_dvd;
    assign w_rem_fix    = (w_fix_signed & r_neg_r) ? (~r_rem + Width'(1)) : r_rem;

    div_step #(
        .Width (Width)
    ) u_div_step (
        .i_rem (r_rem),
        .i_dvd (r_dvd),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_dvd (w_dvd_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_op     <= DIV;
            r_rd     <= '0;
            r_rd_out <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_op    <= md_op_e'(op_i);
                        r_rd    <= rd_i;
                        r_dvd   <= w_abs1;
                        r_dvs   <= w_abs2;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= w_sign1 ^ w_sign2;
                        r_neg_r <= w_sign1;
                        if (w_div_zero || w_ovf) begin
                            r_result <= w_spec_res;
                            r_rd_out <= rd_i;
                            r_valid  <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= w_dvd_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_result <= r_op[1] ? w_rem_fix : w_quo_fix;
                        r_rd_out <= r_rd;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready_o  = (r_state == IDLE);
    assign busy_o   = ~ready_o;
    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign rd_o     = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_rv_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_div_unit
//  Description : Directed self-checking bench for the RV32M divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        abort_i;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_res = 32'd0;
    logic [4:0]  last_rd  = 5'd0;

    localparam logic [1:0] C_DIV  = 2'd0;
    localparam logic [1:0] C_DIVU = 2'd1;
    localparam logic [1:0] C_REM  = 2'd2;
    localparam logic [1:0] C_REMU = 2'd3;

    always #5 clk_i = ~clk_i;

    rv_div_unit #(
        .Width    (32),
        .RegAddrW (5)
    ) u_dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_i     (rd_i),
        .abort_i  (abort_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, then measure latency (cycles after the accepting cycle) and check outputs.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk_i);
        chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
        start_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        rd_i    = rd;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_i);
            if (valid_o) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, result_o, exp_res);
        chk({tag, "_rd"}, {27'd0, rd_o}, {27'd0, rd});
        @(negedge clk_i);
        chk({tag, "_pulse"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_hold"}, result_o, exp_res);
        last_res = exp_res;
        last_rd  = rd;
    endtask

    initial begin
        logic seen;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        op_i    = 2'd0;
        rs1_i   = 32'd0;
        rs2_i   = 32'd0;
        rd_i    = 5'd0;
        #12;
        chk("rst_ready",  {31'd0, ready_o}, 32'd1);
        chk("rst_busy",   {31'd0, busy_o},  32'd0);
        chk("rst_valid",  {31'd0, valid_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_rd",     {27'd0, rd_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        do_op("divu_100_7",  C_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         34);
        do_op("remu_100_7",  C_REMU, 32'd100,        32'd7,          5'd5,  32'd2,          34);
        do_op("div_m7_2",    C_DIV,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  34);
        do_op("rem_m7_2",    C_REM,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  34);
        do_op("div_7_m2",    C_DIV,  32'd7,          32'hFFFF_FFFE,  5'd8,  32'hFFFF_FFFD,  34);
        do_op("rem_7_m2",    C_REM,  32'd7,          32'hFFFF_FFFE,  5'd8,  32'd1,          34);
        do_op("div_ovf",     C_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000,  1);
        do_op("rem_ovf",     C_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          1);
        do_op("divu_z",      C_DIVU, 32'h0000_1234,  32'd0,          5'd12, 32'hFFFF_FFFF,  1);
        do_op("remu_z",      C_REMU, 32'h0000_1234,  32'd0,          5'd13, 32'h0000_1234,  1);
        do_op("div_z_neg",   C_DIV,  32'hFFFF_FFFB,  32'd0,          5'd14, 32'hFFFF_FFFF,  1);
        do_op("rem_z_neg",   C_REM,  32'hFFFF_FFFB,  32'd0,          5'd15, 32'hFFFF_FFFB,  1);
        do_op("divu_max_1",  C_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd16, 32'hFFFF_FFFF,  34);
        do_op("divu_max_m1", C_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  5'd17, 32'd1,          34);
        do_op("remu_big",    C_REMU, 32'hFFFF_FFFF,  32'h8000_0000,  5'd18, 32'h7FFF_FFFF,  34);
        do_op("div_min_2",   C_DIV,  32'h8000_0000,  32'd2,          5'd19, 32'hC000_0000,  34);

        // Abort mid-CALC; an overlapping start_i while busy must be dropped.
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = C_DIVU;
        rs1_i   = 32'd100;
        rs2_i   = 32'd7;
        rd_i    = 5'd9;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk_i);
            if (valid_o) seen = 1'b1;
            if (k == 5) begin
                chk("abort_busy", {31'd0, busy_o}, 32'd1);
                start_i = 1'b1;
                op_i    = C_DIVU;
                rs1_i   = 32'd77;
                rs2_i   = 32'd0;
                rd_i    = 5'd3;
            end
            if (k == 6)  start_i = 1'b0;
            if (k == 10) abort_i = 1'b1;
            if (k == 11) begin
                abort_i = 1'b0;
                chk("abort_ready", {31'd0, ready_o}, 32'd1);
            end
        end
        chk("abort_novalid", {31'd0, seen}, 32'd0);
        chk("abort_res",     result_o, last_res);
        chk("abort_rd",      {27'd0, rd_o}, {27'd0, last_rd});
        do_op("after_abort", C_DIVU, 32'd50, 32'd5, 5'd20, 32'd10, 34);

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = C_DIVU;
        rs1_i   = 32'h0000_FFFF;
        rs2_i   = 32'd3;
        rd_i    = 5'd7;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (int k = 1; k <= 20; k++) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_ready",  {31'd0, ready_o}, 32'd1);
        chk("arst_busy",   {31'd0, busy_o},  32'd0);
        chk("arst_valid",  {31'd0, valid_o}, 32'd0);
        chk("arst_result", result_o, 32'd0);
        chk("arst_rd",     {27'd0, rd_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (valid_o) seen = 1'b1;
        end
        chk("arst_novalid", {31'd0, seen}, 32'd0);
        chk("arst_idle",    {31'd0, ready_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
